// File: rtl/i2c_slave_if.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, byte-stream receive and
// local-supplied byte transmit. Open-drain SDA only, never drives or stretches SCL.
//
// state    | meaning
// IDLE     | bus idle or after STOP, waiting for START
// ADDR     | shifting in the address + R/W byte
// ADDR_ACK | holding ACK for a matched address
// RX       | shifting in a write data byte
// RX_ACK   | holding ACK for a received byte
// TX       | serialising a read byte onto SDA
// TX_ACK   | SDA released, sampling master ACK/NACK
// IGNORE   | not addressed or NACKed, wait for START/STOP
module i2c_slave_if #(
  parameter logic [6:0] SLV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_req_o,
  input  logic [7:0] tx_data_i,
  output logic       rw_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_p, sda_p;
  logic rise, fall, start, stop;

  logic [7:0] sr, sr_n;
  logic [2:0] cnt, cnt_n, bit_idx;
  logic       done, done_n;
  logic       oe_n, rw_n, busy_n, rx_valid_n, tx_req_n;
  logic [7:0] rx_data_n;

  // Synchronisers reset high so a reset on an idle bus sees no edges.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  assign scl_s   = scl_sync[SYNC_STAGES-1];
  assign sda_s   = sda_sync[SYNC_STAGES-1];
  assign rise    = scl_s & ~scl_p;
  assign fall    = ~scl_s & scl_p;
  assign start   = scl_s & scl_p & sda_p & ~sda_s;
  assign stop    = scl_s & scl_p & ~sda_p & sda_s;
  assign bit_idx = cnt - 3'd1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= 3'd7;
      done       <= 1'b0;
      sda_oe_o   <= 1'b0;
      rw_o       <= 1'b0;
      busy_o     <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      cnt        <= cnt_n;
      done       <= done_n;
      sda_oe_o   <= oe_n;
      rw_o       <= rw_n;
      busy_o     <= busy_n;
      rx_data_o  <= rx_data_n;
      rx_valid_o <= rx_valid_n;
      tx_req_o   <= tx_req_n;
    end
  end

  // done marks "8th rise seen" in ADDR/RX and "master ACK seen" in TX_ACK.
  always_comb begin
    state_n    = state;
    sr_n       = sr;
    cnt_n      = cnt;
    done_n     = done;
    oe_n       = sda_oe_o;
    rw_n       = rw_o;
    busy_n     = busy_o;
    rx_data_n  = rx_data_o;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;

    if (stop) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      cnt_n   = 3'd7;
      done_n  = 1'b0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
        end
        ADDR: begin
          if (rise && !done) begin
            sr_n = {sr[6:0], sda_s};
            if (cnt == 3'd0) done_n = 1'b1;
            else             cnt_n  = cnt - 3'd1;
          end else if (fall && done) begin
            if (sr[7:1] == SLV_ADDR) begin
              oe_n     = 1'b1;
              rw_n     = sr[0];
              busy_n   = 1'b1;
              tx_req_n = sr[0];
              state_n  = ADDR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            cnt_n  = 3'd7;
            done_n = 1'b0;
            if (rw_o) begin
              sr_n    = tx_data_i;
              oe_n    = ~tx_data_i[7];
              state_n = TX;
            end else begin
              oe_n    = 1'b0;
              state_n = RX;
            end
          end
        end
        RX: begin
          if (rise && !done) begin
            sr_n = {sr[6:0], sda_s};
            if (cnt == 3'd0) begin
              done_n     = 1'b1;
              rx_data_n  = {sr[6:0], sda_s};
              rx_valid_n = 1'b1;
            end else begin
              cnt_n = cnt - 3'd1;
            end
          end else if (fall && done) begin
            oe_n    = 1'b1;
            state_n = RX_ACK;
          end
        end
        RX_ACK: begin
          if (fall) begin
            oe_n    = 1'b0;
            cnt_n   = 3'd7;
            done_n  = 1'b0;
            state_n = RX;
          end
        end
        TX: begin
          if (fall) begin
            if (cnt != 3'd0) begin
              cnt_n = cnt - 3'd1;
              oe_n  = ~sr[bit_idx];
            end else begin
              oe_n    = 1'b0;
              done_n  = 1'b0;
              state_n = TX_ACK;
            end
          end
        end
        TX_ACK: begin
          if (rise && !done) begin
            if (!sda_s) begin
              tx_req_n = 1'b1;
              done_n   = 1'b1;
            end else begin
              busy_n  = 1'b0;
              state_n = IGNORE;
            end
          end else if (fall && done) begin
            sr_n    = tx_data_i;
            oe_n    = ~tx_data_i[7];
            cnt_n   = 3'd7;
            done_n  = 1'b0;
            state_n = TX;
          end
        end
        IGNORE: begin
          oe_n = 1'b0;
        end
        default: begin
          state_n = IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_if.sv
// Directed bench for i2c_slave_if: bus master model plus scoreboards for received
// bytes and for bytes serialised back on reads.
module tb_i2c_slave_if;

  localparam int Q = 10;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       tx_req_o;
  logic [7:0] tx_data = 8'h00;
  logic       rw_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int rxv_cnt = 0;
  int txreq_cnt = 0;
  bit oe_seen = 1'b0;

  logic [7:0] rx_exp[$];
  logic [7:0] tx_src[$];
  logic [7:0] tx_exp[$];

  assign sda_bus = m_sda & ~sda_oe_o;

  always #5 clk_i = ~clk_i;

  i2c_slave_if dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .tx_req_o   (tx_req_o),
    .tx_data_i  (tx_data),
    .rw_o       (rw_o),
    .busy_o     (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk_i);
    #2;
  endtask

  task automatic bus_start();
    wait_q(); m_sda = 1'b0;
    wait_q(); scl = 1'b0;
  endtask

  task automatic bus_rstart();
    wait_q(); m_sda = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); m_sda = 1'b0;
    wait_q(); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(); m_sda = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); m_sda = 1'b1;
    wait_q();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    wait_q();
    if (glitch) begin
      m_sda = ~b; repeat (3) @(posedge clk_i); #2;
      m_sda = b;  repeat (3) @(posedge clk_i); #2;
      m_sda = ~b; repeat (3) @(posedge clk_i); #2;
    end
    m_sda = b;
    wait_q(); scl = 1'b1;
    wait_q();
    wait_q(); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_q(); m_sda = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); b = sda_bus;
    wait_q(); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit glitch, output bit ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch);
    read_bit(s);
    ack = ~s;
  endtask

  task automatic read_byte(input bit master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      read_bit(s);
      d[i] = s;
    end
    send_bit(~master_ack, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (sda_oe_o) oe_seen = 1'b1;
      if (tx_req_o) begin
        txreq_cnt++;
        if (tx_src.size() != 0) tx_data = tx_src.pop_front();
      end
      if (rx_valid_o) begin
        rxv_cnt++;
        check("rx_expected_pending", rx_exp.size() != 0, 1);
        if (rx_exp.size() != 0) check("rx_data", rx_data_o, rx_exp.pop_front());
      end
    end
  end

  initial begin
    bit ack;
    logic [7:0] rd;
    int base_rx, base_tx;

    // reset values
    repeat (5) @(posedge clk_i); #2;
    check("reset_ctrl", {sda_oe_o, rx_valid_o, tx_req_o, rw_o, busy_o}, 0);
    check("reset_rx_data", rx_data_o, 0);
    rst_i = 1'b1;
    wait_q();

    // write A5, 3C
    base_rx = rxv_cnt;
    bus_start();
    write_byte({7'h42, 1'b0}, 1'b0, ack);
    check("wr_addr_ack", ack, 1);
    check("wr_busy", busy_o, 1);
    check("wr_rw", rw_o, 0);
    rx_exp.push_back(8'hA5);
    write_byte(8'hA5, 1'b0, ack);
    check("wr_a5_ack", ack, 1);
    rx_exp.push_back(8'h3C);
    write_byte(8'h3C, 1'b0, ack);
    check("wr_3c_ack", ack, 1);
    bus_stop();
    check("wr_busy_after_stop", busy_o, 0);
    check("wr_rx_pulses", rxv_cnt - base_rx, 2);

    // wrong address
    base_rx = rxv_cnt;
    oe_seen = 1'b0;
    bus_start();
    write_byte({7'h43, 1'b0}, 1'b0, ack);
    check("bad_addr_nack", ack, 0);
    write_byte(8'h11, 1'b0, ack);
    check("bad_data_nack", ack, 0);
    check("bad_busy", busy_o, 0);
    bus_stop();
    check("bad_oe_never", oe_seen, 0);
    check("bad_rx_pulses", rxv_cnt - base_rx, 0);

    // read C3 (ACK), 5A (NACK)
    base_tx = txreq_cnt;
    tx_src.push_back(8'hC3); tx_exp.push_back(8'hC3);
    tx_src.push_back(8'h5A); tx_exp.push_back(8'h5A);
    bus_start();
    write_byte({7'h42, 1'b1}, 1'b0, ack);
    check("rd_addr_ack", ack, 1);
    check("rd_rw", rw_o, 1);
    check("rd_busy", busy_o, 1);
    read_byte(1'b1, rd);
    check("rd_byte0", rd, tx_exp.pop_front());
    read_byte(1'b0, rd);
    check("rd_byte1", rd, tx_exp.pop_front());
    wait_q();
    check("rd_sda_released", sda_oe_o, 0);
    check("rd_busy_after_nack", busy_o, 0);
    bus_stop();
    check("rd_tx_req_pulses", txreq_cnt - base_tx, 2);

    // write one byte, repeated START, read one byte
    bus_start();
    write_byte({7'h42, 1'b0}, 1'b0, ack);
    check("rs_wr_addr_ack", ack, 1);
    rx_exp.push_back(8'h77);
    write_byte(8'h77, 1'b0, ack);
    check("rs_wr_data_ack", ack, 1);
    check("rs_rw_write", rw_o, 0);
    tx_src.push_back(8'h96); tx_exp.push_back(8'h96);
    bus_rstart();
    write_byte({7'h42, 1'b1}, 1'b0, ack);
    check("rs_rd_addr_ack", ack, 1);
    check("rs_rw_read", rw_o, 1);
    read_byte(1'b0, rd);
    check("rs_rd_byte", rd, tx_exp.pop_front());
    bus_stop();
    check("rs_busy_after_stop", busy_o, 0);

    // reset while the address ACK is held
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h84 >> i) & 8'h01) != 0, 1'b0);
    wait_q();
    check("rst_ack_held", sda_oe_o, 1);
    rst_i = 1'b0;
    #1;
    check("rst_sda_released", sda_oe_o, 0);
    check("rst_ctrl", {rx_valid_o, tx_req_o, rw_o, busy_o}, 0);
    check("rst_rx_data", rx_data_o, 0);
    repeat (3) @(posedge clk_i); #2;
    rst_i = 1'b1;
    bus_stop();
    bus_start();
    write_byte({7'h42, 1'b0}, 1'b0, ack);
    check("post_rst_addr_ack", ack, 1);
    rx_exp.push_back(8'hE7);
    write_byte(8'hE7, 1'b0, ack);
    check("post_rst_data_ack", ack, 1);
    bus_stop();

    // SDA toggling while SCL is low
    bus_start();
    write_byte({7'h42, 1'b0}, 1'b0, ack);
    check("glitch_addr_ack", ack, 1);
    rx_exp.push_back(8'h5C);
    write_byte(8'h5C, 1'b1, ack);
    check("glitch_data_ack", ack, 1);
    check("glitch_busy_held", busy_o, 1);
    bus_stop();
    check("glitch_busy_after_stop", busy_o, 0);

    wait_q();
    check("rx_all_seen", rx_exp.size(), 0);
    check("tx_all_used", tx_src.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
